// File: rtl/shape_pkg.sv
// Shared definitions for the shape scheduler: shape codes, FSM state
// encoding and the index-to-enable decode used by the scheduler.
package shape_pkg;

  localparam logic [1:0] SHAPE_CIRCLE = 2'd0;
  localparam logic [1:0] SHAPE_EIGHT  = 2'd1;
  localparam logic [1:0] SHAPE_SQUARE = 2'd2;
  localparam logic [1:0] SHAPE_SOLID  = 2'd3;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Decode a shape index into the one-hot enable presented to the pulse mux.
  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      SHAPE_CIRCLE: oh = 4'b0001;
      SHAPE_EIGHT:  oh = 4'b0010;
      SHAPE_SQUARE: oh = 4'b0100;
      SHAPE_SOLID:  oh = 4'b1000;
      default:      oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press (0->1 of the stable level).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic raw,
  output logic press_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // Next-state: count while the synchronised level disagrees with the stable one.
  always_comb begin
    sync_d   = {sync_q[0], raw};
    stable_d = stable_q;
    cnt_d    = DB_ZERO;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync_q[1];
        cnt_d    = DB_ZERO;
        // Only a rising stable level is a press; release is silent.
        pulse_d  = sync_q[1];
      end else begin
        cnt_d    = cnt_q + DB_ONE;
      end
    end else begin
      cnt_d = DB_ZERO;
    end
  end

  // Register synchroniser, stable level, counter and the press pulse.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= DB_ZERO;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/shape_scheduler.sv
// Sequences the four XY shape generators through a one-hot enable bus,
// with an all-zero blanking gap between shapes. Advances on a dwell timer
// (auto mode) or on a debounced button press.
module shape_scheduler
  import shape_pkg::*;
#(
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int BLANK_CYCLES    = 1_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic       btn_next_raw,
  input  logic       auto_mode,
  input  logic       pause,
  output logic [3:0] enable_sw,
  output logic [1:0] shape_idx,
  output logic       blanking
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_ZERO = DW_W'(0);
  localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_ZERO = BL_W'(0);
  localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);

  // auto_mode and pause are slide switches treated as quasi-static; only the
  // push-button needs synchronising and debouncing.

  logic [1:0]      rst_sync_q, rst_sync_d;
  logic            rst_int_n;
  logic            press_pulse;
  logic            dwell_expire;

  state_e          state_q, state_d;
  logic [BL_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      en_q, en_d;
  logic            blanking_q, blanking_d;

  // Reset release shifts in ones so deassertion is aligned to sysclk.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser: asserts asynchronously, releases after two edges.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .sysclk      (sysclk),
    .sys_rst_n   (rst_int_n),
    .raw         (btn_next_raw),
    .press_pulse (press_pulse)
  );

  assign dwell_expire = auto_mode && !pause && (dwell_q == DW_LAST);

  // FSM next-state, counters and output values; outputs are precomputed so
  // the registered enable never shows two bits or a stale shape.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    dwell_d     = dwell_q;
    idx_d       = idx_q;
    en_d        = en_q;
    blanking_d  = blanking_q;
    case (state_q)
      ST_BLANK: begin
        en_d       = 4'b0000;
        blanking_d = 1'b1;
        dwell_d    = DW_ZERO;
        // A press arriving here is intentionally ignored (not queued).
        if (blank_cnt_q == BL_LAST) begin
          state_d     = ST_RUN;
          blank_cnt_d = BL_ZERO;
          en_d        = idx_to_onehot(idx_q);
          blanking_d  = 1'b0;
        end else begin
          blank_cnt_d = blank_cnt_q + BL_ONE;
        end
      end
      ST_RUN: begin
        blank_cnt_d = BL_ZERO;
        en_d        = idx_to_onehot(idx_q);
        blanking_d  = 1'b0;
        // Expiry and press together still give a single advance.
        if (dwell_expire || press_pulse) begin
          state_d    = ST_BLANK;
          idx_d      = idx_q + 2'd1;
          dwell_d    = DW_ZERO;
          en_d       = 4'b0000;
          blanking_d = 1'b1;
        end else if (!auto_mode) begin
          dwell_d = DW_ZERO;
        end else if (!pause) begin
          dwell_d = dwell_q + DW_ONE;
        end else begin
          dwell_d = dwell_q;
        end
      end
      default: begin
        state_d     = ST_BLANK;
        blank_cnt_d = BL_ZERO;
        dwell_d     = DW_ZERO;
        en_d        = 4'b0000;
        blanking_d  = 1'b1;
      end
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge sysclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_BLANK;
      blank_cnt_q <= BL_ZERO;
      dwell_q     <= DW_ZERO;
      idx_q       <= SHAPE_CIRCLE;
      en_q        <= 4'b0000;
      blanking_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      blanking_q  <= blanking_d;
    end
  end

  assign enable_sw = en_q;
  assign shape_idx = idx_q;
  assign blanking  = blanking_q;

endmodule
